// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory read port between NUM_REQ
// requesters, with a watchdog that turns a silent memory into a sticky error.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   req_valid    per-requester read request, level-held until its resp_valid
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt          one-hot owner of the in-flight access, zero when idle
//   resp_valid   one-cycle response pulse to the owner
//   resp_data    read data, valid while any resp_valid bit is high
//   mem_req      memory request, held for the whole access
//   mem_addr     memory address, captured at grant
//   mem_ready    memory data-ready strobe (honoured only while busy)
//   mem_data     memory data, sampled with mem_ready
//   busy         access in flight
//   timeout_err  sticky watchdog error
//   err_code     16'hAAAA after a timeout, otherwise 16'h0000
module mem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [15:0]                 err_code
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [15:0] FETCH_ERR = 16'hAAAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [15:0]         err_code_q, err_code_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;
  int unsigned         scan_idx;

  // Round-robin pick: first eligible index above the last owner, wrapping.
  // A requester being answered this cycle is masked so its stale level
  // request cannot win again immediately.
  always_comb begin
    eligible  = req_valid & ~resp_valid_q;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = 32'(last_q) + i;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!win_found && eligible[IDX_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // Address mux for the winning requester.
  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    err_code_d    = err_code_q;
    last_d        = last_q;
    owner_d       = owner_q;
    wdog_d        = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_BUSY;
          gnt_d      = NUM_REQ'(1) << win_idx;
          mem_addr_d = win_addr;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          owner_d    = win_idx;
          wdog_d     = '0;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          state_d      = ST_IDLE;
          resp_data_d  = mem_data;
          resp_valid_d = NUM_REQ'(1) << owner_q;
          gnt_d        = '0;
          mem_req_d    = 1'b0;
          busy_d       = 1'b0;
          last_d       = owner_q;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // This was the last allowed busy cycle without an answer.
          state_d       = ST_ERROR;
          gnt_d         = '0;
          mem_req_d     = 1'b0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          err_code_d    = FETCH_ERR;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      ST_ERROR: begin
        // Sticky until reset.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_code_q    <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      owner_q       <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      err_code_q    <= err_code_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      wdog_q        <= wdog_d;
    end
  end

  assign gnt         = gnt_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (NUM_REQ=2, TIMEOUT=4): a directed vector table,
// then randomized traffic compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] a0 = '0, a1 = '0;
  logic [31:0] req_addr;
  logic [1:0]  gnt, resp_valid;
  logic [15:0] resp_data, mem_addr, mem_data = '0, err_code;
  logic        mem_req, mem_ready = 1'b0, busy, timeout_err;

  assign req_addr = {a1, a0};

  mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data(mem_data), .busy(busy), .timeout_err(timeout_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [15:0] a0, a1;
    logic        rdy;
    logic [15:0] md;
    logic [1:0]  gnt, rsp;
    logic [15:0] rd;
    logic        mreq;
    logic [15:0] maddr;
    logic        bsy;
    logic        terr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [1:0] rv,
                             input logic [15:0] x0, input logic [15:0] x1,
                             input logic rdy, input logic [15:0] md,
                             input logic [1:0] g, input logic [1:0] rsp,
                             input logic [15:0] rd, input logic mreq,
                             input logic [15:0] maddr, input logic bsy,
                             input logic terr);
    vec_t t;
    t.rst = r; t.rv = rv; t.a0 = x0; t.a1 = x1; t.rdy = rdy; t.md = md;
    t.gnt = g; t.rsp = rsp; t.rd = rd; t.mreq = mreq; t.maddr = maddr;
    t.bsy = bsy; t.terr = terr;
    return t;
  endfunction

  function automatic logic [63:0] pack_out(input logic [1:0] g, input logic [1:0] r,
                                           input logic [15:0] d, input logic mq,
                                           input logic [15:0] ma, input logic b,
                                           input logic te, input logic [15:0] ec);
    return {9'd0, g, r, d, mq, ma, b, te, ec};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (gnt,rsp,data,mreq,addr,busy,terr,code)",
               name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_out();
    return pack_out(gnt, resp_valid, resp_data, mem_req, mem_addr, busy,
                    timeout_err, err_code);
  endfunction

  // ---------------- reference model ----------------
  // Mode: 0 waiting for work, 1 access outstanding, 2 dead after timeout.
  int          m_mode, m_owner, m_waited, m_last;
  logic [1:0]  e_gnt, e_rsp;
  logic [15:0] e_rd, e_maddr, e_code;
  logic        e_mreq, e_busy, e_terr;

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_waited = 0; m_last = N - 1;
    e_gnt = '0; e_rsp = '0; e_rd = '0; e_maddr = '0; e_code = '0;
    e_mreq = 0; e_busy = 0; e_terr = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [1:0] served, elig;
    int         w;
    if (!rst) begin
      model_reset();
      return;
    end
    served = e_rsp;
    e_rsp  = '0;
    if (m_mode == 0) begin
      elig = req_valid & ~served;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) begin
        m_mode = 1; m_owner = w; m_waited = 0;
        e_gnt = 2'(1 << w);
        e_maddr = (w == 0) ? a0 : a1;
        e_mreq = 1; e_busy = 1;
      end
    end else if (m_mode == 1) begin
      m_waited++;
      if (mem_ready) begin
        e_rd = mem_data; e_rsp = 2'(1 << m_owner);
        e_gnt = '0; e_mreq = 0; e_busy = 0;
        m_last = m_owner; m_mode = 0;
      end else if (m_waited == TMO) begin
        m_mode = 2; e_gnt = '0; e_mreq = 0; e_busy = 0;
        e_terr = 1; e_code = 16'hAAAA;
      end
    end
  endtask

  initial begin
    vec_t t;
    // single requester
    vecs.push_back(v(0,2'b00,16'h0010,16'h0000,0,16'h0000, 2'b00,2'b00,16'h0000,0,16'h0000,0,0));
    vecs.push_back(v(1,2'b01,16'h0010,16'h0000,0,16'h0000, 2'b01,2'b00,16'h0000,1,16'h0010,1,0));
    vecs.push_back(v(1,2'b01,16'h0010,16'h0000,0,16'h0000, 2'b01,2'b00,16'h0000,1,16'h0010,1,0));
    vecs.push_back(v(1,2'b01,16'h0010,16'h0000,1,16'hBEEF, 2'b00,2'b01,16'hBEEF,0,16'h0010,0,0));
    vecs.push_back(v(1,2'b00,16'h0010,16'h0000,0,16'h0000, 2'b00,2'b00,16'hBEEF,0,16'h0010,0,0));
    // contention 0,1,0,1
    vecs.push_back(v(0,2'b00,16'h0100,16'h0200,0,16'h0000, 2'b00,2'b00,16'h0000,0,16'h0000,0,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,0,16'h0000, 2'b01,2'b00,16'h0000,1,16'h0100,1,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,1,16'h1111, 2'b00,2'b01,16'h1111,0,16'h0100,0,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,0,16'h0000, 2'b10,2'b00,16'h1111,1,16'h0200,1,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,1,16'h2222, 2'b00,2'b10,16'h2222,0,16'h0200,0,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,0,16'h0000, 2'b01,2'b00,16'h2222,1,16'h0100,1,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,1,16'h3333, 2'b00,2'b01,16'h3333,0,16'h0100,0,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,0,16'h0000, 2'b10,2'b00,16'h3333,1,16'h0200,1,0));
    vecs.push_back(v(1,2'b11,16'h0100,16'h0200,1,16'h4444, 2'b00,2'b10,16'h4444,0,16'h0200,0,0));
    vecs.push_back(v(1,2'b00,16'h0100,16'h0200,0,16'h0000, 2'b00,2'b00,16'h4444,0,16'h0200,0,0));
    // spurious ready while idle
    vecs.push_back(v(1,2'b00,16'h0100,16'h0200,1,16'h5555, 2'b00,2'b00,16'h4444,0,16'h0200,0,0));
    // owner drops request and changes address mid-access
    vecs.push_back(v(1,2'b10,16'h0100,16'h0200,0,16'h0000, 2'b10,2'b00,16'h4444,1,16'h0200,1,0));
    vecs.push_back(v(1,2'b00,16'h0100,16'h0999,0,16'h0000, 2'b10,2'b00,16'h4444,1,16'h0200,1,0));
    vecs.push_back(v(1,2'b00,16'h0100,16'h0999,1,16'h6666, 2'b00,2'b10,16'h6666,0,16'h0200,0,0));
    // stale request held through resp_valid
    vecs.push_back(v(1,2'b01,16'h0030,16'h0999,0,16'h0000, 2'b01,2'b00,16'h6666,1,16'h0030,1,0));
    vecs.push_back(v(1,2'b01,16'h0030,16'h0999,1,16'h7777, 2'b00,2'b01,16'h7777,0,16'h0030,0,0));
    vecs.push_back(v(1,2'b01,16'h0030,16'h0999,0,16'h0000, 2'b00,2'b00,16'h7777,0,16'h0030,0,0));
    vecs.push_back(v(1,2'b01,16'h0030,16'h0999,0,16'h0000, 2'b01,2'b00,16'h7777,1,16'h0030,1,0));
    vecs.push_back(v(1,2'b01,16'h0030,16'h0999,1,16'h8888, 2'b00,2'b01,16'h8888,0,16'h0030,0,0));
    vecs.push_back(v(1,2'b00,16'h0030,16'h0999,0,16'h0000, 2'b00,2'b00,16'h8888,0,16'h0030,0,0));
    // ready in the 4th busy cycle is accepted
    vecs.push_back(v(1,2'b10,16'h0030,16'h0040,0,16'h0000, 2'b10,2'b00,16'h8888,1,16'h0040,1,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1,2'b10,16'h0030,16'h0040,0,16'h0000, 2'b10,2'b00,16'h8888,1,16'h0040,1,0));
    vecs.push_back(v(1,2'b10,16'h0030,16'h0040,1,16'h9999, 2'b00,2'b10,16'h9999,0,16'h0040,0,0));
    vecs.push_back(v(1,2'b00,16'h0030,16'h0040,0,16'h0000, 2'b00,2'b00,16'h9999,0,16'h0040,0,0));
    // no ready: timeout after 4 busy cycles, then sticky
    vecs.push_back(v(1,2'b01,16'h0050,16'h0040,0,16'h0000, 2'b01,2'b00,16'h9999,1,16'h0050,1,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1,2'b01,16'h0050,16'h0040,0,16'h0000, 2'b01,2'b00,16'h9999,1,16'h0050,1,0));
    vecs.push_back(v(1,2'b01,16'h0050,16'h0040,0,16'h0000, 2'b00,2'b00,16'h9999,0,16'h0050,0,1));
    vecs.push_back(v(1,2'b11,16'h0050,16'h0040,1,16'h1357, 2'b00,2'b00,16'h9999,0,16'h0050,0,1));
    vecs.push_back(v(1,2'b11,16'h0050,16'h0040,1,16'h1357, 2'b00,2'b00,16'h9999,0,16'h0050,0,1));
    // reset mid-access, requester 0 wins afterwards
    vecs.push_back(v(0,2'b00,16'h0060,16'h0040,0,16'h0000, 2'b00,2'b00,16'h0000,0,16'h0000,0,0));
    vecs.push_back(v(1,2'b01,16'h0060,16'h0040,0,16'h0000, 2'b01,2'b00,16'h0000,1,16'h0060,1,0));
    vecs.push_back(v(0,2'b01,16'h0060,16'h0040,1,16'h2468, 2'b00,2'b00,16'h0000,0,16'h0000,0,0));
    vecs.push_back(v(1,2'b11,16'h0060,16'h0070,0,16'h0000, 2'b01,2'b00,16'h0000,1,16'h0060,1,0));
    vecs.push_back(v(1,2'b11,16'h0060,16'h0070,1,16'h1234, 2'b00,2'b01,16'h1234,0,16'h0060,0,0));
    vecs.push_back(v(1,2'b00,16'h0060,16'h0070,0,16'h0000, 2'b00,2'b00,16'h1234,0,16'h0060,0,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      t = vecs[i];
      rst = t.rst; req_valid = t.rv; a0 = t.a0; a1 = t.a1;
      mem_ready = t.rdy; mem_data = t.md;
      @(posedge clk); #1;
      check($sformatf("vec[%0d]", i), dut_out(),
            pack_out(t.gnt, t.rsp, t.rd, t.mreq, t.maddr, t.bsy, t.terr,
                     t.terr ? 16'hAAAA : 16'h0000));
    end

    // ---------------- randomized traffic ----------------
    rst = 0; req_valid = '0; mem_ready = 0;
    model_reset();
    @(posedge clk); #1;
    check("rand_reset", dut_out(),
          pack_out(e_gnt, e_rsp, e_rd, e_mreq, e_maddr, e_busy, e_terr, e_code));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_mode == 2) rst = ($urandom_range(3) != 0);
      else             rst = ($urandom_range(199) != 0);
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[r] = 1'b1;
            if (r == 0) a0 = 16'($urandom); else a1 = 16'($urandom);
          end
        end else if (e_rsp[r]) begin
          if ($urandom_range(1) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          if (r == 0) a0 = 16'($urandom); else a1 = 16'($urandom);
        end
      end
      mem_ready = ($urandom_range(1) == 0);
      mem_data  = 16'($urandom);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand[%0d]", cyc), dut_out(),
            pack_out(e_gnt, e_rsp, e_rd, e_mreq, e_maddr, e_busy, e_terr, e_code));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
